signal_modulator: RTL and testbench

BPSK transmit-side modulator, the counterpart of the demodulator chain. It accepts one PACKET_WIDTH-byte packet over a valid/ready handshake and frames it as preamble, sync word, payload, then tail. Each bit modulates a sampled sine carrier with phase 0 for '1' and phase π for '0'. Output is an offset-binary DATA_WIDTH code driving the DAC pio pins, updated only on sample_tick.

---
 rtl/bpsk_tx_pkg.sv | 13 +
 rtl/carrier_lut.sv | 14 +
 rtl/signal_modulator.sv | 89 ++++++++
 tb/tb_signal_modulator.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/bpsk_tx_pkg.sv
// bpsk_tx_pkg: shared types and elaboration-time helpers for the BPSK transmitter
package bpsk_tx_pkg;
  typedef enum logic [2:0] {IDLE, PREAMBLE, SYNC, PAYLOAD, TAIL} state_t;
  localparam logic [7:0] SYNC_WORD_DEF = 8'hA5;
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
  function automatic int sine_sample(input int k, input int n, input int dw);
    real a;
    a = real'((1 << (dw - 1)) - 1);
    return int'(a * $sin(6.283185307179586 * real'(k) / real'(n)));
  endfunction
endpackage

// File: rtl/carrier_lut.sv
// carrier_lut: combinational sine ROM, one signed sample per phase index
module carrier_lut import bpsk_tx_pkg::*; #(
  parameter int DATA_WIDTH = 12,
  parameter int SAMPLES_PER_CYCLE = 16
) (
  input  logic [$clog2(SAMPLES_PER_CYCLE)-1:0] phase,
  output logic signed [DATA_WIDTH-1:0] sample
);
  logic signed [DATA_WIDTH-1:0] rom [SAMPLES_PER_CYCLE];
  for (genvar k = 0; k < SAMPLES_PER_CYCLE; k++) begin : g_rom
    assign rom[k] = DATA_WIDTH'(sine_sample(k, SAMPLES_PER_CYCLE, DATA_WIDTH));
  end
  assign sample = rom[phase];
endmodule

// File: rtl/signal_modulator.sv
// signal_modulator: BPSK framer/modulator (preamble, sync, payload, tail) driving an offset-binary DAC
module signal_modulator import bpsk_tx_pkg::*; #(
  parameter int DATA_WIDTH = 12,
  parameter int PACKET_WIDTH = 4,
  parameter int SAMPLES_PER_CYCLE = 16,
  parameter int CYCLES_PER_BIT = 4,
  parameter int PREAMBLE_BITS = 16,
  parameter logic [7:0] SYNC_WORD = SYNC_WORD_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_tick,
  input  logic [PACKET_WIDTH*8-1:0] packet,
  input  logic packet_valid,
  output logic packet_ready,
  output logic busy,
  output logic done,
  output logic bit_out,
  output logic [DATA_WIDTH-1:0] sample_out
);
  localparam int PHW = $clog2(SAMPLES_PER_CYCLE);
  localparam int CW = cnt_w(CYCLES_PER_BIT);
  localparam int NB = PACKET_WIDTH * 8;
  localparam int BW = cnt_w(PREAMBLE_BITS + 8 + NB);
  localparam logic [DATA_WIDTH-1:0] MID = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  state_t state, state_nxt;
  logic [PHW-1:0] phase;
  logic [CW-1:0] cyc;
  logic [BW-1:0] bit_cnt, bit_len;
  logic [NB+7:0] sr;
  logic cur_bit, bit_end, last;
  logic signed [DATA_WIDTH-1:0] s;
  logic [DATA_WIDTH-1:0] s_u;
  carrier_lut #(.DATA_WIDTH(DATA_WIDTH), .SAMPLES_PER_CYCLE(SAMPLES_PER_CYCLE)) u_lut (
    .phase(phase),
    .sample(s)
  );
  assign s_u = s;
  assign bit_end = sample_tick && state != IDLE && phase == '1 && cyc == CW'(CYCLES_PER_BIT - 1);
  assign bit_len = state == PREAMBLE ? BW'(PREAMBLE_BITS) : state == SYNC ? BW'(8) :
                   state == PAYLOAD ? BW'(NB) : BW'(1);
  assign last = bit_end && bit_cnt == bit_len - 1'b1;
  assign bit_out = cur_bit;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    if (state == IDLE && packet_valid) state_nxt = PREAMBLE;
    else if (last) state_nxt = state == PREAMBLE ? SYNC : state == SYNC ? PAYLOAD :
                               state == PAYLOAD ? TAIL : IDLE;
  end
  always_comb begin
    packet_ready = state == IDLE;
    busy = state != IDLE;
    done = state == TAIL && last;
  end
  // sync word and payload share one shift register, so both just shift out MSB first
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      phase <= '0;
      cyc <= '0;
      bit_cnt <= '0;
      sr <= '0;
      cur_bit <= 1'b0;
      sample_out <= MID;
    end else if (state == IDLE) begin
      if (packet_valid) begin
        phase <= '0;
        cyc <= '0;
        bit_cnt <= '0;
        sr <= {SYNC_WORD, packet};
        cur_bit <= 1'b1;
      end
    end else if (sample_tick) begin
      sample_out <= state == TAIL ? MID : cur_bit ? MID + s_u : MID - s_u;
      phase <= phase + 1'b1;
      if (phase == '1) cyc <= bit_end ? '0 : cyc + 1'b1;
      if (bit_end) begin
        bit_cnt <= last ? '0 : bit_cnt + 1'b1;
        if (state == PREAMBLE && !last) cur_bit <= ~cur_bit;
        else if (state == TAIL || (state == PAYLOAD && last)) cur_bit <= 1'b0;
        else begin
          cur_bit <= sr[NB+7];
          sr <= sr << 1;
        end
      end
    end
endmodule

// File: tb/tb_signal_modulator.sv
// tb_signal_modulator: directed frames with random packets/tick gaps against a per-tick waveform model
module tb_signal_modulator;
  localparam int MID = 2048;
  localparam int SPC = 16;
  localparam int TPB = 64;
  localparam int NB = 56;
  localparam int TOTAL = (NB + 1) * TPB;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic sample_tick, packet_valid, packet_ready, busy, done, bit_out;
  logic [31:0] packet;
  logic [11:0] sample_out;
  int compared = 0;
  int mismatched = 0;
  signal_modulator dut (
    .clk(clk),
    .rst_n(rst_n),
    .sample_tick(sample_tick),
    .packet(packet),
    .packet_valid(packet_valid),
    .packet_ready(packet_ready),
    .busy(busy),
    .done(done),
    .bit_out(bit_out),
    .sample_out(sample_out)
  );
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end
  function automatic int lut(input int k);
    return int'(2047.0 * $sin(2.0 * 3.141592653589793 * real'(k) / real'(SPC)));
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [31:0] pkt);
    @(negedge clk);
    packet = pkt;
    packet_valid = 1'b1;
    sample_tick = 1'b1;
    #1 chk("accept_ready", packet_ready, 1);
    @(posedge clk);
    #1 packet_valid = 1'b0;
    sample_tick = 1'b0;
    chk("accept_busy", busy, 1);
    chk("accept_mid", sample_out, MID);
  endtask
  task automatic frame(input logic [31:0] pkt, input int abort_at, input int pulse_at,
                       input logic hold, input logic [31:0] nxt);
    logic q[$];
    logic [7:0] sw;
    logic eb;
    int b, k, e;
    sw = 8'hA5;
    for (int i = 0; i < 16; i++) q.push_back(i % 2 == 0);
    for (int i = 0; i < 8; i++) q.push_back(sw[7-i]);
    for (int i = 0; i < 32; i++) q.push_back(pkt[31-i]);
    for (int t = 0; t < TOTAL; t++) begin
      if (t == abort_at) begin
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("abort_sample", sample_out, MID);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_ready", packet_ready, 1);
        chk("abort_bit", bit_out, 0);
        @(negedge clk) rst_n = 1'b1;
        return;
      end
      if (t == pulse_at) begin
        @(negedge clk);
        packet = ~pkt;
        packet_valid = 1'b1;
        #1 chk("pulse_ready", packet_ready, 0);
        @(posedge clk);
        #1 packet_valid = 1'b0;
        chk("pulse_busy", busy, 1);
      end
      if (hold && t == 1) begin
        packet = nxt;
        packet_valid = 1'b1;
      end
      if ($urandom_range(0, 7) == 0) @(negedge clk);
      @(negedge clk);
      sample_tick = 1'b1;
      b = t / TPB;
      k = t % SPC;
      eb = b < NB ? q[b] : 1'b0;
      #1 chk("bit_out", bit_out, eb);
      chk("done", done, t == TOTAL - 1);
      @(posedge clk);
      #1 sample_tick = 1'b0;
      e = b >= NB ? MID : eb ? MID + lut(k) : MID - lut(k);
      chk("sample", sample_out, e);
    end
    chk("end_ready", packet_ready, 1);
    chk("end_busy", busy, 0);
    chk("end_done", done, 0);
    if (hold) begin
      @(posedge clk);
      #1 chk("b2b_busy", busy, 1);
      packet_valid = 1'b0;
      chk("b2b_mid", sample_out, MID);
    end
  endtask
  initial begin
    logic [31:0] r1, r2, r3, r4;
    sample_tick = 1'b0;
    packet_valid = 1'b0;
    packet = '0;
    #3 rst_n = 1'b0;
    #4 chk("rst_sample", sample_out, MID);
    chk("rst_ready", packet_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bit", bit_out, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      sample_tick = 1'b1;
      #1 chk("idle_done", done, 0);
      @(posedge clk);
      #1 sample_tick = 1'b0;
      chk("idle_sample", sample_out, MID);
      chk("idle_ready", packet_ready, 1);
      chk("idle_busy", busy, 0);
    end
    send(32'hDEADBEEF);
    frame(32'hDEADBEEF, -1, -1, 1'b0, '0);
    send(32'h00000000);
    frame(32'h00000000, -1, 2500, 1'b0, '0);
    r1 = $urandom;
    r2 = $urandom;
    r3 = $urandom;
    r4 = $urandom;
    send(r1);
    frame(r1, -1, -1, 1'b1, r2);
    frame(r2, -1, 2000, 1'b0, '0);
    send(r3);
    frame(r3, 1200, -1, 1'b0, '0);
    send(r4);
    frame(r4, -1, -1, 1'b0, '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
